// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one async transmitter between NUM_REQ byte
// requesters. Round-robin grant is held for a whole packet, or until
// MAX_PKT bytes have been sent. Each tx_start is sequenced against
// tx_busy, and a transmitter that never raises busy is reported as a fault.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int MAX_PKT      = 16,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   tx_start_o,
    output logic [7:0]             tx_data_o,
    input  logic                   tx_busy_i,
    output logic                   tx_fault_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_PKT + 1);
    localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               last_q, last_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_fault_q, tx_fault_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   next_rr;
    logic [7:0]         owner_data;

    assign next_rr    = IDX_W'((int'(owner_q) + 1) % NUM_REQ);
    assign owner_data = req_data_i[8*int'(owner_q) +: 8];

    // Find the first valid lane scanning upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_found && req_valid_i[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            end
        end
    end

    // Next-state and registered-output logic for the grant/transmit sequencer.
    always_comb begin
        // NOTE: every *_d gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        byte_cnt_d  = byte_cnt_q;
        timer_d     = timer_q;
        last_d      = last_q;
        req_ready_d = '0;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        tx_fault_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d    = NUM_REQ'(1) << pick_idx;
                    owner_d    = pick_idx;
                    byte_cnt_d = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                // Owner may stall mid-packet; the grant is simply held.
                if (req_valid_i[owner_q] && !tx_busy_i) begin
                    tx_start_d  = 1'b1;
                    tx_data_d   = owner_data;
                    req_ready_d = NUM_REQ'(1) << owner_q;
                    last_d      = req_last_i[owner_q];
                    byte_cnt_d  = byte_cnt_q + CNT_W'(1);
                    timer_d     = '0;
                    state_d     = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (tx_busy_i) begin
                    state_d = WAIT_LO;
                end else if (timer_q == TMR_W'(BUSY_TIMEOUT - 1)) begin
                    tx_fault_d = 1'b1;
                    grant_d    = '0;
                    rr_ptr_d   = next_rr;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            WAIT_LO: begin
                if (!tx_busy_i) begin
                    if (last_q || byte_cnt_q == CNT_W'(MAX_PKT)) begin
                        grant_d  = '0;
                        rr_ptr_d = next_rr;
                        state_d  = IDLE;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge; there is no asynchronous path.
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            byte_cnt_q  <= '0;
            timer_q     <= '0;
            last_q      <= 1'b0;
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_fault_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register sees pre-edge values.
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            byte_cnt_q  <= byte_cnt_d;
            timer_q     <= timer_d;
            last_q      <= last_d;
            req_ready_q <= req_ready_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            tx_fault_q  <= tx_fault_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign grant_o     = grant_q;
    assign tx_start_o  = tx_start_q;
    assign tx_data_o   = tx_data_q;
    assign tx_fault_o  = tx_fault_q;

endmodule
